// File: rtl/fmul_pkg.sv
// Shared FP32 constants and pipeline record types for the FMUL normalise/round stage.
// The guard/sticky fields exist only when FMUL_ROUND_RNE_EN is defined.
package fmul_pkg;

  localparam int EXP_BITS  = 8;
  localparam int FRAC_BITS = 23;
  localparam int PROD_BITS = 48;
  localparam int BIAS      = 127;
  localparam int EXP_W     = 10;
  localparam int EXP_MAX   = 255;
  localparam logic [FRAC_BITS-1:0] QNAN_FRAC = 23'h400000;

  typedef struct packed {
    logic                       sign;
    logic signed [EXP_W-1:0]    exp;
    logic [FRAC_BITS-1:0]       mant;
`ifdef FMUL_ROUND_RNE_EN
    logic                       guard;
    logic                       sticky;
`endif
    logic                       primal;
    logic [EXP_BITS-1:0]        primal_exp;
    logic [FRAC_BITS-1:0]       primal_frac;
    logic                       error;
  } s1_reg_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_BITS-1:0]  exp;
    logic [FRAC_BITS-1:0] frac;
    logic                 error;
    logic                 overflow;
    logic                 underflow;
  } result_t;

endpackage

// File: rtl/fmul_normalize_round_if.sv
// Upstream-consumer and downstream-producer signals of the FMUL normalise/round stage.
// The stage itself connects through the slave modport; its driver uses master.
interface fmul_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  A_exp;
  logic [7:0]  B_exp;
  logic        primal;
  logic [7:0]  primal_exp;
  logic [22:0] primal_frac;
  logic        error;
  logic [47:0] partial_frac;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_error;
  logic        out_overflow;
  logic        out_underflow;

  modport master (
    output in_valid, in_sign, A_exp, B_exp, primal, primal_exp, primal_frac,
           error, partial_frac, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_error,
           out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, A_exp, B_exp, primal, primal_exp, primal_frac,
           error, partial_frac, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_error,
           out_overflow, out_underflow
  );
endinterface

// File: rtl/fmul_round_pack.sv
// Combinational round (RNE when FMUL_ROUND_RNE_EN is defined, else truncate),
// exponent carry, overflow/underflow saturation and special-case packing.
module fmul_round_pack
  import fmul_pkg::*;
(
  input  s1_reg_t s1,
  output result_t res
);

  localparam logic signed [EXP_W-1:0] EXP_SAT  = EXP_W'(EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

  logic                    round_up;
  logic [FRAC_BITS:0]      mant_rnd;
  logic signed [EXP_W-1:0] exp_rnd;

`ifdef FMUL_ROUND_RNE_EN
  assign round_up = s1.guard & (s1.sticky | s1.mant[0]);
`else
  assign round_up = 1'b0;
`endif

  // A carry out of the mantissa leaves the low bits all zero, so frac needs no mux.
  assign mant_rnd = {1'b0, s1.mant} + (FRAC_BITS+1)'(round_up);
  assign exp_rnd  = s1.exp + EXP_W'(mant_rnd[FRAC_BITS]);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    res           = '0;
    res.sign      = s1.sign;
    if (s1.error) begin
      res.exp     = 8'hFF;
      res.frac    = QNAN_FRAC;
      res.error   = 1'b1;
    end else if (s1.primal) begin
      res.exp     = s1.primal_exp;
      res.frac    = s1.primal_frac;
    end else if (exp_rnd >= EXP_SAT) begin
      res.exp      = 8'hFF;
      res.overflow = 1'b1;
    end else if (exp_rnd <= EXP_ZERO) begin
      res.underflow = 1'b1;
    end else begin
      res.exp     = exp_rnd[EXP_BITS-1:0];
      res.frac    = mant_rnd[FRAC_BITS-1:0];
    end
  end

endmodule

// File: rtl/fmul_normalize_round.sv
// Two-stage FMUL normalise/round pipeline with valid/ready flow control.
// Define FMUL_ROUND_RNE_EN for round-to-nearest-even; otherwise rounds toward zero.
module fmul_normalize_round #(
  parameter int BIAS  = fmul_pkg::BIAS,
  parameter int EXP_W = fmul_pkg::EXP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  fmul_normalize_round_if.slave bus
);

  fmul_pkg::s1_reg_t s1_next;
  fmul_pkg::s1_reg_t s1_q;
  fmul_pkg::result_t rounded;
  fmul_pkg::result_t out_q;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic norm;
  logic signed [EXP_W-1:0] exp_sum;

  assign s2_adv      = !s2_valid || bus.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // A product in [2,4) has its leading one at bit 47 and needs a one-place shift.
  assign norm    = bus.partial_frac[47];
  assign exp_sum = EXP_W'(bus.A_exp) + EXP_W'(bus.B_exp) - EXP_W'(BIAS) + EXP_W'(norm);

  always_comb begin
    s1_next             = '0;
    s1_next.sign        = bus.in_sign;
    s1_next.exp         = exp_sum;
    s1_next.mant        = norm ? bus.partial_frac[46:24] : bus.partial_frac[45:23];
`ifdef FMUL_ROUND_RNE_EN
    s1_next.guard       = norm ? bus.partial_frac[23] : bus.partial_frac[22];
    s1_next.sticky      = norm ? |bus.partial_frac[22:0] : |bus.partial_frac[21:0];
`endif
    s1_next.primal      = bus.primal;
    s1_next.primal_exp  = bus.primal_exp;
    s1_next.primal_frac = bus.primal_frac;
    s1_next.error       = bus.error;
  end

`ifndef FMUL_ROUND_RNE_EN
  logic unused_lsbs;
  assign unused_lsbs = ^bus.partial_frac[22:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_q    <= '0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) out_q <= rounded;
    end
  end

  // NOTE: the S1 payload carries no reset; s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) s1_q <= s1_next;
  end

  fmul_round_pack u_round_pack (
    .s1  (s1_q),
    .res (rounded)
  );

  assign bus.out_valid     = s2_valid;
  assign bus.out_sign      = out_q.sign;
  assign bus.out_exp       = out_q.exp;
  assign bus.out_frac      = out_q.frac;
  assign bus.out_error     = out_q.error;
  assign bus.out_overflow  = out_q.overflow;
  assign bus.out_underflow = out_q.underflow;

endmodule
